// File: rtl/ladybird_uart_receiver.sv
// ---------------------------------------------------------------------------
// ladybird_uart_receiver
//
// Receive half of the ladybird UART link. The block oversamples the
// asynchronous serial line with the system clock and recovers 8N1 frames:
// one start bit, eight data bits LSB first, and one stop bit. Each good byte
// is delivered through a one-entry holding register with a valid/ready
// handshake. Framing and overrun errors are reported as one-cycle pulses.
//
// Parameters
//   WTIME      bit period minus one, in clk cycles (minimum 1)
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous active-high reset
//   rx         in   1  asynchronous serial line, idle high
//   valid      out  1  holding register contains a byte
//   data       out  8  received byte, stable while valid is high
//   ready      in   1  consumer takes the byte when valid & ready
//   frame_err  out  1  one-cycle pulse: stop bit sampled low
//   overrun    out  1  one-cycle pulse: good byte dropped, holding reg full
// ---------------------------------------------------------------------------
module ladybird_uart_receiver #(
    parameter logic [15:0] WTIME = 16'h28B0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       valid,
    output logic [7:0] data,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // Full bit period reload and the half-period used to reach mid-bit.
    localparam logic [19:0] FULL_C = {4'h0, WTIME};
    localparam logic [19:0] HALF_C = {5'h00, WTIME[15:1]};

    // Synchronizer
    logic        rx_meta_r;
    logic        rx_s;

    // Frame recovery state
    state_t      state_r;
    state_t      state_nxt_s;
    logic [19:0] cnt_r;
    logic [19:0] cnt_nxt_s;
    logic [2:0]  idx_r;
    logic [2:0]  idx_nxt_s;
    logic [7:0]  sh_r;
    logic [7:0]  sh_nxt_s;
    logic        cnt_zero_s;
    logic        byte_good_s;
    logic        frame_err_nxt_s;

    // Delivery
    logic        accept_s;
    logic        load_s;
    logic        valid_nxt_s;
    logic        overrun_nxt_s;

    assign cnt_zero_s = (cnt_r == 20'd0);
    assign accept_s   = valid & ready;

    // Two-flop synchronizer on the serial line; both stages idle high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s      <= rx_meta_r;
        end
    end

    // Next-state logic for frame recovery: counts to mid-bit and samples.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        idx_nxt_s       = idx_r;
        sh_nxt_s        = sh_r;
        byte_good_s     = 1'b0;
        frame_err_nxt_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_nxt_s   = HALF_C;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_START: begin
                if (cnt_zero_s) begin
                    // A line that is high again at mid-start was a glitch.
                    if (!rx_s) begin
                        cnt_nxt_s   = FULL_C;
                        idx_nxt_s   = 3'd0;
                        state_nxt_s = ST_DATA;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 20'd1;
                end
            end

            ST_DATA: begin
                if (cnt_zero_s) begin
                    // LSB arrives first, so shift in from the top.
                    sh_nxt_s  = {rx_s, sh_r[7:1]};
                    cnt_nxt_s = FULL_C;
                    if (idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        idx_nxt_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 20'd1;
                end
            end

            ST_STOP: begin
                if (cnt_zero_s) begin
                    if (rx_s) begin
                        byte_good_s = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        frame_err_nxt_s = 1'b1;
                        state_nxt_s     = ST_BREAK;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 20'd1;
                end
            end

            ST_BREAK: begin
                // Hold here until the line idles so a stuck-low line
                // does not keep generating frames.
                if (rx_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BREAK;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Frame recovery registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 20'd0;
            idx_r   <= 3'd0;
            sh_r    <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            sh_r    <= sh_nxt_s;
        end
    end

    // Holding-register decision: a consumer pop on the same edge frees
    // the slot for the arriving byte.
    always_comb begin
        load_s        = 1'b0;
        overrun_nxt_s = 1'b0;
        valid_nxt_s   = valid;

        if (byte_good_s) begin
            if (!valid || accept_s) begin
                load_s      = 1'b1;
                valid_nxt_s = 1'b1;
            end else begin
                overrun_nxt_s = 1'b1;
                valid_nxt_s   = valid;
            end
        end else if (accept_s) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid;
        end
    end

    // Registered outputs: holding register and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            data      <= 8'h00;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            valid     <= valid_nxt_s;
            frame_err <= frame_err_nxt_s;
            overrun   <= overrun_nxt_s;
            if (load_s) begin
                data <= sh_r;
            end else begin
                data <= data;
            end
        end
    end

endmodule

// File: tb/tb_ladybird_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_ladybird_uart_receiver
//
// Drives 8N1 frames into the receiver with WTIME=15 and compares every
// cycle against a reference model. The model knows only the frame-level
// rules: each frame sent produces one event at a fixed edge (falling edge
// plus 3 + H + 9*P), where a good stop bit offers the byte to a one-entry
// holding register and a low stop bit produces a framing pulse.
// ---------------------------------------------------------------------------
module tb_ladybird_uart_receiver;

    localparam logic [15:0] WT = 16'd15;
    localparam int          P  = 16;
    localparam int          H  = 7;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    ladybird_uart_receiver #(.WTIME(WT)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .valid     (valid),
        .data      (data),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    typedef struct {
        int         edge_n;
        logic [7:0] b;
        logic       good;
    } ev_t;

    ev_t        evq[$];
    ev_t        ev;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_mis = 0;
    int         ready_mode = 1;
    logic       chk_en = 1'b0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_fe = 1'b0;
    logic       m_ov = 1'b0;
    logic       acc;
    logic       hit;

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: frame events applied to a one-entry holding register.
    always @(posedge clk) begin
        cyc  = cyc + 1;
        m_fe = 1'b0;
        m_ov = 1'b0;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            evq.delete();
        end else begin
            acc = m_valid && ready;
            hit = 1'b0;
            while (evq.size() > 0 && evq[0].edge_n < cyc) void'(evq.pop_front());
            if (evq.size() > 0 && evq[0].edge_n == cyc) begin
                ev  = evq.pop_front();
                hit = 1'b1;
            end
            if (hit && ev.good) begin
                if (!m_valid || acc) begin
                    m_data  = ev.b;
                    m_valid = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end else begin
                if (hit) m_fe = 1'b1;
                if (acc) m_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_val("valid", {7'd0, valid}, {7'd0, m_valid});
            check_val("data", data, m_data);
            check_val("frame_err", {7'd0, frame_err}, {7'd0, m_fe});
            check_val("overrun", {7'd0, overrun}, {7'd0, m_ov});
        end
    end

    // Consumer: always off, always on, or rarely ready.
    initial begin
        ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       ready = 1'b0;
                1:       ready = 1'b1;
                default: ready = ($urandom_range(0, 255) == 0);
            endcase
        end
    end

    // Called just after a negedge; returns just after a negedge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        ev_t e;
        rx       = 1'b0;
        e.edge_n = cyc + 1 + 3 + H + 9 * P;
        e.b      = b;
        e.good   = stop_bit;
        evq.push_back(e);
        repeat (P) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (P) @(negedge clk);
        end
        rx = stop_bit;
        repeat (P) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        logic       bad;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_valid", {7'd0, valid}, 8'd0);
        check_val("rst_data", data, 8'h00);
        check_val("rst_frame_err", {7'd0, frame_err}, 8'd0);
        check_val("rst_overrun", {7'd0, overrun}, 8'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        idle(10);

        // Single frame, consumer ready.
        send_frame(8'h55, 1'b1);
        idle(20);

        // Two frames with no consumer: second one overruns.
        ready_mode = 0;
        idle(2);
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(20);
        check_val("hold_valid", {7'd0, valid}, 8'd1);
        check_val("hold_data", data, 8'hA5);
        ready_mode = 1;
        idle(5);
        check_val("drain_valid", {7'd0, valid}, 8'd0);

        // Short glitch shorter than half a bit.
        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(40);

        // Framing error, line held low, then recovery.
        send_frame(8'hFF, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        idle(10);
        send_frame(8'h81, 1'b1);
        idle(20);

        // Reset during data bit 4; upper bits high so no false start follows.
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (5 * P + 8) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check_val("mid_rst_valid", {7'd0, valid}, 8'd0);
                check_val("mid_rst_data", data, 8'h00);
                check_val("mid_rst_frame_err", {7'd0, frame_err}, 8'd0);
                rst = 1'b0;
            end
        join
        idle(20);
        send_frame(8'h0F, 1'b1);
        idle(20);
        check_val("post_rst_data", data, 8'h0F);

        // Back-to-back frames as a transmitter would send them.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h5A, 1'b1);
        send_frame(8'hC3, 1'b1);
        idle(30);
        check_val("loop_last", data, 8'hC3);

        // Random traffic with a slow consumer and occasional bad stop bits.
        ready_mode = 2;
        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, !bad);
            if (bad) begin
                rx = 1'b0;
                repeat ($urandom_range(0, 30)) @(negedge clk);
                idle(8 + $urandom_range(0, 10));
            end else begin
                idle($urandom_range(0, 12));
            end
        end
        ready_mode = 1;
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
